// File: rtl/imem_readback_dumper.sv
// imem_readback_dumper: streams a range of instruction memory out over valid/ready
// with addresses, keeping a running additive checksum of accepted words.
module imem_readback_dumper #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   cur_addr_q, rd_addr_q, out_addr_q;
  logic [ADDR_W:0]     remaining_q;
  logic [DATA_W-1:0]   out_data_q, checksum_q;
  logic                rd_en_q, out_valid_q, out_last_q, done_q;
  logic [ADDR_W-1:0]   next_addr_d;
  logic                last_d;
  assign next_addr_d = cur_addr_q + 1'b1;
  assign last_d      = remaining_q == {{ADDR_W{1'b0}}, 1'b1};
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign checksum  = checksum_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rd_addr_q   <= '0;
      out_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      // abort outranks a same-cycle handshake, so the word in flight is never summed
      if (abort && state_q != IDLE) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            cur_addr_q  <= base_addr;
            remaining_q <= count;
            checksum_q  <= '0;
            state_q     <= (count == '0) ? DONE : ISSUE;
            done_q      <= count == '0;
            rd_en_q     <= count != '0;
            rd_addr_q   <= (count == '0) ? rd_addr_q : base_addr;
          end
          ISSUE: state_q <= CAPTURE;
          CAPTURE: begin
            out_data_q  <= rd_data;
            out_addr_q  <= cur_addr_q;
            out_last_q  <= last_d;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
          SEND: if (out_ready) begin
            checksum_q  <= checksum_q + out_data_q;
            remaining_q <= remaining_q - 1'b1;
            cur_addr_q  <= next_addr_d;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= last_d ? DONE : ISSUE;
            done_q      <= last_d;
            rd_en_q     <= !last_d;
            rd_addr_q   <= last_d ? rd_addr_q : next_addr_d;
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
